sysid_uptime: RTL
=================

Name: sysid_uptime

Overview:
Parametrised system-identification peripheral on the Avalon-MM control bus.
- Extends a constant ID/timestamp responder with a registered read path, a prescaled free-running uptime counter, a scratch register and a control/status register.
- Lets software confirm hardware identity, bus liveness and elapsed run time.
- Sits beside the CPU as a read-mostly slave; one clock domain.

Parameters:
ID_VALUE, 32'h6379D3C7, system ID returned at word 0
TIMESTAMP, 32'd0, build timestamp returned at word 1
CNT_W, 48, uptime counter width; legal range 33..64
PRESCALE, 1, clocks per uptime increment; legal range 1..65535
HB_DIV, 25000000, heartbeat half-period in clocks (used only with the optional feature)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  3  word address
read  in  1  read strobe, one cycle per access
write  in  1  write strobe, one cycle per access
writedata  in  32  write data
readdata  out  32  registered read data
readdatavalid  out  1  high one cycle after an accepted read
heartbeat  out  1  present only when SYSID_HEARTBEAT_EN is defined

Behaviour:
- Reset is asynchronous and active-low. On reset assertion:
  - readdata=0, readdatavalid=0.
  - Uptime counter, prescaler, hi-shadow, SCRATCH and OVF cleared to 0.
  - EN=1.
  - heartbeat=0 (when present).
- Register map (word addresses):
  - 0 ID: read-only, returns ID_VALUE.
  - 1 TIMESTAMP: read-only, returns TIMESTAMP.
  - 2 UPTIME_LO: read-only, returns counter[31:0]. The same read also latches counter[CNT_W-1:32] into the hi-shadow.
  - 3 UPTIME_HI: read-only, returns the hi-shadow, zero-extended to 32 bits. It does not re-sample the counter.
  - 4 SCRATCH: read/write, 32 bits.
  - 5 CTRL: bit0 EN (RW); bit1 CLR (write-1 action, always reads 0); bit2 OVF (sticky, write-1-to-clear). Bits 31:3 read 0.
  - 6 INFO: read-only, returns {8'd1 version, 8'(CNT_W), 16'(PRESCALE)}.
  - 7: reads 0; writes ignored.
- Read timing: no wait states; fixed latency 1.
  - A read in cycle N drives readdata and readdatavalid=1 in cycle N+1.
  - readdata holds its value until the next read; readdatavalid=0 otherwise.
  - Back-to-back reads are accepted every cycle.
- Write timing: takes effect at the clock edge ending the write cycle.
  - read and write asserted together: the write is performed, and the read returns the pre-write value.
- Uptime counting:
  - When EN=1, the prescaler counts 0..PRESCALE-1.
  - On its terminal count the counter increments and the prescaler returns to 0.
  - PRESCALE=1: the counter increments every enabled clock.
  - EN=0 freezes both the prescaler and the counter.
- Wrap-around: when the counter goes from all-ones to 0, OVF is set in that cycle. OVF stays set until software writes 1 to bit2.
  - If a wrap and a W1C land in the same cycle, set wins.
- CLR: writing CTRL with bit1=1 zeroes the counter and prescaler in that cycle, taking priority over any increment.
  - The hi-shadow and OVF are unaffected.
  - A CTRL write applies EN and CLR together.
- Atomic 64-bit read: software reads LO then HI. HI reflects the counter at the LO read, even if a carry occurs between the two reads.
- Illegal parameter values produce a simulation $error at elaboration.

Optional Feature:
Macro SYSID_HEARTBEAT_EN.
- Defined: the heartbeat port exists and toggles every HB_DIV clocks from reset, independent of EN. It is driven by a dedicated counter from 0 to HB_DIV-1.
- Undefined: the heartbeat port and its counter are absent. All register behaviour is unchanged.

Test Plan:
- Reset, then read addr0, addr1, addr6 with CNT_W=48, PRESCALE=1 -> readdata 0x6379D3C7, 0x00000000, 0x01300001, each with readdatavalid exactly one cycle after read.
- Write SCRATCH=0xA5A5_5A5A, then read and write on the same cycle with 0x1234_5678 -> the overlapped read returns 0xA5A55A5A; a subsequent read returns 0x12345678.
- PRESCALE=4, EN=1, wait 40 clocks, read LO -> value 10 (±1 for access alignment); write CTRL=0 (EN=0), wait 100 clocks -> LO is unchanged.
- Force counter to 0x0000_FFFF_FFFF (CNT_W=48), read LO -> 0xFFFFFFFF; next cycle carry occurs; read HI -> 0x00000000 (shadow); read LO then HI again -> 0x00000000 / 0x00000001.
- Counter at all-ones wraps -> OVF=1; write CTRL=0x5 (EN=1, W1C OVF) in the same cycle as a forced second wrap -> OVF remains 1.
- With SYSID_HEARTBEAT_EN and HB_DIV=5 -> heartbeat toggles every 5 clocks; assert reset_n=0 asynchronously mid-count -> heartbeat, readdata, counter and SCRATCH are 0 immediately and EN reads 1 after release.

Source files
------------

// File: rtl/sysid_uptime.sv
// sysid_uptime: Avalon-MM system ID, prescaled uptime counter, scratch and control/status registers.
// Define SYSID_HEARTBEAT_EN to add the heartbeat output and its divider.
module sysid_uptime #(
  parameter logic [31:0] ID_VALUE  = 32'h6379D3C7,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter int          CNT_W     = 48,
  parameter int          PRESCALE  = 1,
  parameter int          HB_DIV    = 25000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
`ifdef SYSID_HEARTBEAT_EN
  output logic        readdatavalid,
  output logic        heartbeat
`else
  output logic        readdatavalid
`endif
);
  if (CNT_W < 33 || CNT_W > 64) begin : g_bad_cnt_w
    $error("sysid_uptime: CNT_W must be in 33..64");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("sysid_uptime: PRESCALE must be in 1..65535");
  end
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-33:0] hi;
  logic [15:0]       pre;
  logic [31:0]       scratch, rd_mux;
  logic              en, ovf;
  logic              wr_ctrl, tc, clr, wrap;
  assign wr_ctrl = write && address == 3'd5;
  assign tc      = en && pre == 16'(PRESCALE - 1);
  assign clr     = wr_ctrl && writedata[1];
  // A clear suppresses the increment, so it also suppresses a wrap.
  assign wrap    = tc && !clr && &cnt;
  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0:    rd_mux = ID_VALUE;
      3'd1:    rd_mux = TIMESTAMP;
      3'd2:    rd_mux = cnt[31:0];
      3'd3:    rd_mux = 32'(hi);
      3'd4:    rd_mux = scratch;
      3'd5:    rd_mux = {29'd0, ovf, 1'b0, en};
      3'd6:    rd_mux = {8'd1, 8'(CNT_W), 16'(PRESCALE)};
      default: rd_mux = '0;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
      cnt           <= '0;
      pre           <= '0;
      hi            <= '0;
      scratch       <= '0;
      en            <= 1'b1;
      ovf           <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      if (read && address == 3'd2) hi <= cnt[CNT_W-1:32];
      if (clr) begin
        cnt <= '0;
        pre <= '0;
      end else if (en) begin
        pre <= tc ? 16'd0 : pre + 16'd1;
        if (tc) cnt <= cnt + CNT_W'(1);
      end
      if (write && address == 3'd4) scratch <= writedata;
      if (wr_ctrl) en <= writedata[0];
      if (wrap) ovf <= 1'b1;
      else if (wr_ctrl && writedata[2]) ovf <= 1'b0;
    end
  end
`ifdef SYSID_HEARTBEAT_EN
  logic [31:0] hb_cnt;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt    <= '0;
      heartbeat <= 1'b0;
    end else if (hb_cnt == 32'(HB_DIV - 1)) begin
      hb_cnt    <= '0;
      heartbeat <= ~heartbeat;
    end else begin
      hb_cnt <= hb_cnt + 32'd1;
    end
  end
`endif
endmodule
